// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux_seq block:
//   - FSM state encoding (mux_state_e)
//   - i_mode encodings (MODE_MANUAL / MODE_SCAN)
//   - debug tap bit positions above the N one-hot select bits
// No ports; imported with "import mux_pkg::*;".
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } mux_state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // The tap vector is N one-hot select bits followed by these flags.
  // The offsets are relative to N, so the absolute index is N + offset.
  localparam int TAP_SCAN_OFS = 0;
  localparam int TAP_HOLD_OFS = 1;

  function automatic int tap_scan_idx(input int n);
    return n + TAP_SCAN_OFS;
  endfunction

  function automatic int tap_hold_idx(input int n);
    return n + TAP_HOLD_OFS;
  endfunction

endpackage

// File: rtl/mux_seq_dwell.sv
// -----------------------------------------------------------------------------
// mux_seq_dwell
// Dwell counter for the scan sequencer. It counts 0..DWELL-1 and wraps.
// o_expire is high while the count sits on its last value, which is the
// cycle on which the sequencer steps to the next channel.
// Priority: reset > hold > clear > load > count enable.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_clr        force the count to 0
//   i_load       load i_load_val
//   i_load_val   value for i_load
//   i_hold       freeze the count
//   i_en         advance the count
//   o_expire     count == DWELL-1
// -----------------------------------------------------------------------------
module mux_seq_dwell #(
  parameter  int DWELL = 16,
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_hold,
  input  logic          i_en,
  output logic          o_expire
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_hold) begin
      cnt_d = cnt_q;
    end else if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DWELL=1 the count is stuck at 0 == LAST, so every cycle expires.
  assign o_expire = (cnt_q == LAST);

endmodule

// File: rtl/mux_seq.sv
// -----------------------------------------------------------------------------
// mux_seq
// Registered N-channel, W-bit multiplexer with a manual-select mode and an
// automatic round-robin scan mode that shows each channel for DWELL cycles.
// Optional debug taps are built when MUX_SEQ_TAP_EN is defined; otherwise
// o_tap is tied to zero.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (priority over everything)
//   i_data   N*W channel data, channel k at [k*W +: W]
//   i_sel    manual channel select
//   i_mode   0 = manual, 1 = scan
//   i_hold   freeze output, channel and dwell counter
//   o_data   selected data, registered (1-cycle latency)
//   o_sel    channel currently driving o_data
//   o_valid  o_data is meaningful
//   o_wrap   one-cycle pulse when the scan returns from N-1 to 0
//   o_err    one-cycle pulse for an out-of-range manual select
//   o_tap    [N-1:0] one-hot of o_sel, [N] in scan, [N+1] registered hold
// Handshake: there is none; o_valid is a level qualifier, high from the first
// cycle after IDLE until the next reset, and consumers may sample o_data on
// any cycle where o_valid is high.
// -----------------------------------------------------------------------------
module mux_seq
  import mux_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int N     = 4,
  parameter  int DWELL = 16,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  i_data,
  input  logic [SELW-1:0] i_sel,
  input  logic            i_mode,
  input  logic            i_hold,
  output logic [W-1:0]    o_data,
  output logic [SELW-1:0] o_sel,
  output logic            o_valid,
  output logic            o_wrap,
  output logic            o_err,
  output logic [N+1:0]    o_tap
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);
  localparam int              DCW     = (DWELL > 1) ? $clog2(DWELL) : 1;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                        input logic [SELW-1:0] s);
    pick = '0;
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) pick = d[k*W +: W];
    end
  endfunction

  function automatic logic in_range(input logic [SELW-1:0] s);
    in_range = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) in_range = 1'b1;
    end
  endfunction

  mux_state_e      state_q, state_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;

  logic            cnt_clr, cnt_load, cnt_hold, cnt_en, cnt_expire;
  logic            man_ok;

  assign man_ok = in_range(i_sel);

  mux_seq_dwell #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (cnt_clr),
    .i_load     (cnt_load),
    .i_load_val ({DCW{1'b0}}),
    .i_hold     (cnt_hold),
    .i_en       (cnt_en),
    .o_expire   (cnt_expire)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    data_d   = data_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_hold = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_d  = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        ch_d    = '0;
        cnt_clr = 1'b1;
        state_d = (i_mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      end

      ST_MANUAL: begin
        if (i_hold) begin
          // Everything keeps its value; mode is re-sampled once hold drops.
          cnt_hold = 1'b1;
        end else begin
          sel_d   = i_sel;
          data_d  = man_ok ? pick(i_data, i_sel) : '0;
          valid_d = 1'b1;
          err_d   = ~man_ok;
          if (i_mode == MODE_SCAN) begin
            // Scan resumes from the channel shown now, with a full dwell.
            state_d  = ST_SCAN;
            ch_d     = man_ok ? i_sel : '0;
            cnt_load = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
      end

      ST_SCAN: begin
        if (i_hold) begin
          cnt_hold = 1'b1;
        end else begin
          sel_d   = ch_q;
          data_d  = pick(i_data, ch_q);
          valid_d = 1'b1;
          cnt_en  = 1'b1;
          // o_sel trails ch by one cycle, so a wrap is the first cycle
          // where ch is 0 while the previous output was channel N-1.
          wrap_d  = (ch_q == '0) && (sel_q == LAST_CH);
          if (cnt_expire) begin
            ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          end
          if (i_mode == MODE_MANUAL) begin
            state_d = ST_MANUAL;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;
  assign o_err   = err_q;

`ifdef MUX_SEQ_TAP_EN
  logic [N+1:0] tap_q, tap_d;

  always_comb begin
    tap_d = '0;
    // One-hot follows the value being loaded into o_sel; an out-of-range
    // select matches no bit, and err suppresses the decode explicitly.
    for (int k = 0; k < N; k++) begin
      tap_d[k] = valid_d && !err_d && (sel_d == SELW'(k));
    end
    tap_d[tap_scan_idx(N)] = (state_q == ST_SCAN);
    tap_d[tap_hold_idx(N)] = i_hold && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign o_tap = tap_q;
`else
  assign o_tap = '0;
`endif

endmodule

// File: tb/tb_mux_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_seq
// Directed bench for mux_seq. Three instances share clock, reset and inputs:
//   u_a : N=4, DWELL=3  (reset, manual, scan period, hold, reset mid-scan)
//   u_b : N=4, DWELL=2  (manual select 3 switched into scan)
//   u_c : N=3, DWELL=1  (out-of-range manual select, advance every cycle)
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so each sample reflects the inputs applied before that edge.
// Tap expectations depend on MUX_SEQ_TAP_EN.
// -----------------------------------------------------------------------------
module tb_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_data;
  logic [1:0]  i_sel;
  logic        i_mode;
  logic        i_hold;

  logic [7:0] a_data, b_data, c_data;
  logic [1:0] a_sel, b_sel, c_sel;
  logic       a_valid, b_valid, c_valid;
  logic       a_wrap, b_wrap, c_wrap;
  logic       a_err, b_err, c_err;
  logic [5:0] a_tap, b_tap;
  logic [4:0] c_tap;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mux_seq #(.W(8), .N(4), .DWELL(3)) u_a (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_sel(i_sel),
    .i_mode(i_mode), .i_hold(i_hold), .o_data(a_data), .o_sel(a_sel),
    .o_valid(a_valid), .o_wrap(a_wrap), .o_err(a_err), .o_tap(a_tap)
  );

  mux_seq #(.W(8), .N(4), .DWELL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_sel(i_sel),
    .i_mode(i_mode), .i_hold(i_hold), .o_data(b_data), .o_sel(b_sel),
    .o_valid(b_valid), .o_wrap(b_wrap), .o_err(b_err), .o_tap(b_tap)
  );

  mux_seq #(.W(8), .N(3), .DWELL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .i_data(i_data[23:0]), .i_sel(i_sel),
    .i_mode(i_mode), .i_hold(i_hold), .o_data(c_data), .o_sel(c_sel),
    .o_valid(c_valid), .o_wrap(c_wrap), .o_err(c_err), .o_tap(c_tap)
  );

  // Hand-written expected sequences.
  logic [1:0] a_scan_t [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
  logic [1:0] b_sw_t   [5]  = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
  logic       b_wr_t   [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] c_sw_t   [5]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic       c_wr_t   [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [5:0] a_tap_t  [4]  = '{6'b010001, 6'b010010, 6'b010100, 6'b011000};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] data,
                         input logic [1:0] sel, input logic valid,
                         input logic wrap, input logic err);
    check({tag, ".data"},  a_data,  data);
    check({tag, ".sel"},   a_sel,   sel);
    check({tag, ".valid"}, a_valid, valid);
    check({tag, ".wrap"},  a_wrap,  wrap);
    check({tag, ".err"},   a_err,   err);
  endtask

  task automatic check_tap_a(input string tag, input logic [5:0] exp_en);
`ifdef MUX_SEQ_TAP_EN
    check(tag, a_tap, exp_en);
`else
    check(tag, a_tap, 6'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // ---- reset, manual select 2 ----
    rst_n  = 1'b0;
    i_data = 32'h13121110;
    i_sel  = 2'd2;
    i_mode = 1'b0;
    i_hold = 1'b0;
    step();
    step();
    check_a("rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    check_tap_a("rst.tap", 6'd0);
    check("rst.c_valid", c_valid, 1'b0);

    rst_n = 1'b1;
    step();
    check("idle.valid", a_valid, 1'b0);
    check("idle.data", a_data, 8'h00);
    step();
    check_a("man1", 8'h12, 2'd2, 1'b1, 1'b0, 1'b0);
    check_tap_a("man1.tap", 6'b000100);
    check("man1.c_data", c_data, 8'h12);

    // one-cycle latency: new data on channel 2 appears after one edge
    i_data = 32'h13551110;
    step();
    check("lat.data", a_data, 8'h55);

    // ---- out-of-range select on the 3-channel instance ----
    i_data = 32'h13121110;
    i_sel  = 2'd3;
    step();
    check("oor.c_data", c_data, 8'h00);
    check("oor.c_sel", c_sel, 2'd3);
    check("oor.c_err", c_err, 1'b1);
    check("oor.c_valid", c_valid, 1'b1);
    check("oor.c_tap", c_tap, 5'd0);
    check("oor.a_data", a_data, 8'h13);
    check("oor.a_err", a_err, 1'b0);
    i_sel = 2'd2;
    step();
    check("oor_end.c_err", c_err, 1'b0);
    check("oor_end.c_data", c_data, 8'h12);

    // ---- manual select 3 switched to scan ----
    i_sel = 2'd3;
    step();
    check("sw0.b_sel", b_sel, 2'd3);
    i_mode = 1'b1;
    step();
    check("sw1.b_sel", b_sel, 2'd3);
    check("sw1.b_data", b_data, 8'h13);
    check("sw1.c_err", c_err, 1'b1);
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("sw_b%0d.sel", s), b_sel, b_sw_t[s]);
      check($sformatf("sw_b%0d.wrap", s), b_wrap, b_wr_t[s]);
      check($sformatf("sw_c%0d.sel", s), c_sel, c_sw_t[s]);
      check($sformatf("sw_c%0d.wrap", s), c_wrap, c_wr_t[s]);
    end

    // ---- full scan period from reset, DWELL=3 ----
    rst_n = 1'b0;
    step();
    step();
    check_a("rst2", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle2.valid", a_valid, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      check_a($sformatf("scan%0d", k), 8'h10 + 8'(a_scan_t[k]), a_scan_t[k],
              1'b1, (k == 12), 1'b0);
      check_tap_a($sformatf("scan%0d.tap", k), a_tap_t[a_scan_t[k]]);
    end

    // ---- hold at ch=1, cnt=1 for 5 cycles ----
    i_hold = 1'b1;
    i_data = 32'hA3A2A1A0;
    for (int h = 0; h < 5; h++) begin
      step();
      check_a($sformatf("hold%0d", h), 8'h11, 2'd1, 1'b1, 1'b0, 1'b0);
      check_tap_a($sformatf("hold%0d.tap", h), 6'b110010);
    end
    i_hold = 1'b0;
    i_data = 32'h13121110;
    step();
    check_a("rel0", 8'h11, 2'd1, 1'b1, 1'b0, 1'b0);
    check_tap_a("rel0.tap", 6'b010010);
    step();
    check_a("rel1", 8'h11, 2'd1, 1'b1, 1'b0, 1'b0);
    step();
    check_a("rel2", 8'h12, 2'd2, 1'b1, 1'b0, 1'b0);

    // ---- reset mid-scan at ch=2, with hold asserted ----
    rst_n  = 1'b0;
    i_hold = 1'b1;
    step();
    check_a("rst3", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    check_tap_a("rst3.tap", 6'd0);
    rst_n  = 1'b1;
    i_hold = 1'b0;
    step();
    check("idle3.valid", a_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("restart%0d.sel", k), a_sel, a_scan_t[k]);
      check($sformatf("restart%0d.valid", k), a_valid, 1'b1);
    end

    // ---- scan back to manual ----
    i_mode = 1'b0;
    i_sel  = 2'd2;
    step();
    check("s2m0.sel", a_sel, 2'd1);
    step();
    check_a("s2m1", 8'h12, 2'd2, 1'b1, 1'b0, 1'b0);
    check_tap_a("s2m1.tap", 6'b000100);

    // ---- hold outranks a mode change; mode re-sampled at release ----
    i_hold = 1'b1;
    i_mode = 1'b1;
    i_sel  = 2'd1;
    step();
    step();
    check_a("hmode", 8'h12, 2'd2, 1'b1, 1'b0, 1'b0);
    i_hold = 1'b0;
    i_mode = 1'b0;
    step();
    check_a("hmode_rel", 8'h11, 2'd1, 1'b1, 1'b0, 1'b0);
    i_sel = 2'd3;
    step();
    check_a("hmode_man", 8'h13, 2'd3, 1'b1, 1'b0, 1'b0);
    check_tap_a("hmode_man.tap", 6'b001000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
